mmio_io_hub: RTL and testbench

Parametrised memory-mapped I/O hub that replaces the fixed KEY/SW/HEX/LEDR mapping of the single-cycle core with a device set generalised in width and count. Adds switch debouncing, per-device status registers (Ready/Overrun/IE), a programmable millisecond timer, and a combined interrupt line. Sits on the core's data-side bus beside the data memory controller. The core's address decode routes loads and stores here when `hit`=1.

---
 rtl/mmio_io_hub_if.sv | 14 +
 rtl/mmio_io_hub.sv | 234 +++++++++++++++++++++++
 tb/tb_mmio_io_hub.sv | 314 +++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/mmio_io_hub_if.sv
// Data-side bus between the core and the MMIO hub: zero-wait loads, posedge-sampled stores.
interface mmio_io_hub_if #(
  parameter int DBITS = 32
);
  logic [DBITS-1:0] addr;
  logic [DBITS-1:0] wdata;
  logic             we;
  logic             re;
  logic             hit;
  logic [DBITS-1:0] rdata;

  modport master (output addr, wdata, we, re, input hit, rdata);
  modport slave  (input addr, wdata, we, re, output hit, rdata);
endinterface

// File: rtl/mmio_io_hub.sv
// Memory-mapped I/O hub: HEX/LEDR outputs, synchronised keys, debounced switches,
// millisecond timer, per-device Ready/Overrun/IE status and a combined interrupt.
module mmio_io_hub #(
  parameter int DBITS             = 32,
  parameter int NUM_KEYS          = 4,
  parameter int NUM_SW            = 10,
  parameter int NUM_LEDR          = 10,
  parameter int NUM_HEX           = 4,
  parameter int DEBOUNCE_CYCLES   = 500000,
  parameter int TIMER_TICK_CYCLES = 50000,
  parameter logic [DBITS-1:0] ADDR_HEX   = 32'hF0000000,
  parameter logic [DBITS-1:0] ADDR_LEDR  = 32'hF0000004,
  parameter logic [DBITS-1:0] ADDR_KDATA = 32'hF0000010,
  parameter logic [DBITS-1:0] ADDR_SDATA = 32'hF0000014,
  parameter logic [DBITS-1:0] ADDR_TCNT  = 32'hF0000020,
  parameter logic [DBITS-1:0] ADDR_TLIM  = 32'hF0000024,
  parameter logic [DBITS-1:0] ADDR_KCTRL = 32'hF0000110,
  parameter logic [DBITS-1:0] ADDR_SCTRL = 32'hF0000114,
  parameter logic [DBITS-1:0] ADDR_TCTRL = 32'hF0000120
) (
  input  logic                  clk,
  input  logic                  reset,
  mmio_io_hub_if.slave          bus,
  input  logic [NUM_KEYS-1:0]   KEY,
  input  logic [NUM_SW-1:0]     SW,
  output logic [NUM_LEDR-1:0]   LEDR,
  output logic [7*NUM_HEX-1:0]  HEX,
  output logic                  irq
);

  localparam int unsigned DB_W  = $clog2(DEBOUNCE_CYCLES + 1);
  localparam int unsigned PRE_W = $clog2(TIMER_TICK_CYCLES + 1);
  localparam logic [DB_W-1:0]  DB_LAST  = DB_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(TIMER_TICK_CYCLES - 1);

  localparam int unsigned DEV_KEY = 0;
  localparam int unsigned DEV_SW  = 1;
  localparam int unsigned DEV_TMR = 2;

  typedef enum logic [3:0] {
    SEL_NONE,
    SEL_HEX,
    SEL_LEDR,
    SEL_KDATA,
    SEL_SDATA,
    SEL_TCNT,
    SEL_TLIM,
    SEL_KCTRL,
    SEL_SCTRL,
    SEL_TCTRL
  } regSel_e;

  regSel_e sel;

  logic [4*NUM_HEX-1:0] hexData;
  logic [NUM_LEDR-1:0]  ledrData;
  logic [NUM_KEYS-1:0]  keySync1;
  logic [NUM_KEYS-1:0]  kData;
  logic [NUM_SW-1:0]    swSync1;
  logic [NUM_SW-1:0]    swSync2;
  logic [NUM_SW-1:0]    sData;
  logic [DB_W-1:0]      dbCnt;
  logic [PRE_W-1:0]     preCnt;
  logic [DBITS-1:0]     tCnt;
  logic [DBITS-1:0]     tLim;

  logic [2:0] ready, overrun, ie;
  logic [2:0] readyNext, overrunNext, ieNext;
  logic [2:0] ev, rdClr, ctrlWr;

  logic wr, keyEv, swEv, tick, tcntWr, tmrEv;

  function automatic logic [6:0] seg7(input logic [3:0] n);
    logic [6:0] s;
    case (n)
      4'h0: s = 7'b1000000;
      4'h1: s = 7'b1111001;
      4'h2: s = 7'b0100100;
      4'h3: s = 7'b0110000;
      4'h4: s = 7'b0011001;
      4'h5: s = 7'b0010010;
      4'h6: s = 7'b0000010;
      4'h7: s = 7'b1111000;
      4'h8: s = 7'b0000000;
      4'h9: s = 7'b0010000;
      4'hA: s = 7'b0001000;
      4'hB: s = 7'b0000011;
      4'hC: s = 7'b1000110;
      4'hD: s = 7'b0100001;
      4'hE: s = 7'b0000110;
      default: s = 7'b0001110;
    endcase
    return s;
  endfunction

  function automatic logic [4:0] ctrlWord(input logic r, input logic o, input logic e);
    return {e, 1'b0, o, 1'b0, r};
  endfunction

  // ---------------- address decode and read mux ----------------
  always_comb begin
    sel = SEL_NONE;
    case (bus.addr)
      ADDR_HEX:   sel = SEL_HEX;
      ADDR_LEDR:  sel = SEL_LEDR;
      ADDR_KDATA: sel = SEL_KDATA;
      ADDR_SDATA: sel = SEL_SDATA;
      ADDR_TCNT:  sel = SEL_TCNT;
      ADDR_TLIM:  sel = SEL_TLIM;
      ADDR_KCTRL: sel = SEL_KCTRL;
      ADDR_SCTRL: sel = SEL_SCTRL;
      ADDR_TCTRL: sel = SEL_TCTRL;
      default:    sel = SEL_NONE;
    endcase
  end

  assign bus.hit = (sel != SEL_NONE);

  always_comb begin
    bus.rdata = '0;
    case (sel)
      SEL_HEX:   bus.rdata[4*NUM_HEX-1:0] = hexData;
      SEL_LEDR:  bus.rdata[NUM_LEDR-1:0]  = ledrData;
      SEL_KDATA: bus.rdata[NUM_KEYS-1:0]  = kData;
      SEL_SDATA: bus.rdata[NUM_SW-1:0]    = sData;
      SEL_TCNT:  bus.rdata = tCnt;
      SEL_TLIM:  bus.rdata = tLim;
      SEL_KCTRL: bus.rdata[4:0] = ctrlWord(ready[DEV_KEY], overrun[DEV_KEY], ie[DEV_KEY]);
      SEL_SCTRL: bus.rdata[4:0] = ctrlWord(ready[DEV_SW], overrun[DEV_SW], ie[DEV_SW]);
      SEL_TCTRL: bus.rdata[4:0] = ctrlWord(ready[DEV_TMR], overrun[DEV_TMR], ie[DEV_TMR]);
      default:   bus.rdata = '0;
    endcase
  end

  // ---------------- event detection ----------------
  assign wr     = bus.we & bus.hit;
  assign tcntWr = wr && (sel == SEL_TCNT);
  assign tick   = (preCnt == PRE_LAST);

  // kData doubles as the second synchroniser stage, so its change is the key event
  assign keyEv = (keySync1 != kData);
  assign swEv  = (dbCnt == DB_LAST) && (swSync2 != sData);
  assign tmrEv = tick && !tcntWr && (tLim != '0) && (tCnt == tLim - DBITS'(1));

  assign ev     = {tmrEv, swEv, keyEv};
  assign rdClr  = {1'b0, bus.re && (sel == SEL_SDATA), bus.re && (sel == SEL_KDATA)};
  assign ctrlWr = {wr && (sel == SEL_TCTRL), wr && (sel == SEL_SCTRL), wr && (sel == SEL_KCTRL)};

  // Hardware set wins over a same-cycle clear; Overrun only counts an unacknowledged Ready.
  always_comb begin
    readyNext   = ready;
    overrunNext = overrun;
    ieNext      = ie;
    for (int unsigned i = 0; i < 3; i++) begin
      logic clrR, clrO;
      clrR = rdClr[i] | (ctrlWr[i] & ~bus.wdata[0]);
      clrO = ctrlWr[i] & ~bus.wdata[2];
      readyNext[i]   = ev[i] | (ready[i] & ~clrR);
      overrunNext[i] = (ev[i] & ready[i] & ~clrR) | (overrun[i] & ~clrO);
      if (ctrlWr[i]) ieNext[i] = bus.wdata[4];
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      ready   <= '0;
      overrun <= '0;
      ie      <= '0;
    end else begin
      ready   <= readyNext;
      overrun <= overrunNext;
      ie      <= ieNext;
    end
  end

  // ---------------- output data registers ----------------
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      hexData  <= '0;
      ledrData <= '0;
    end else begin
      if (wr && sel == SEL_HEX)  hexData  <= bus.wdata[4*NUM_HEX-1:0];
      if (wr && sel == SEL_LEDR) ledrData <= bus.wdata[NUM_LEDR-1:0];
    end
  end

  // ---------------- keys and switches ----------------
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      keySync1 <= '0;
      kData    <= '0;
      swSync1  <= '0;
      swSync2  <= '0;
      sData    <= '0;
      dbCnt    <= '0;
    end else begin
      keySync1 <= ~KEY;
      kData    <= keySync1;
      swSync1  <= SW;
      swSync2  <= swSync1;
      if (swSync1 != swSync2)   dbCnt <= '0;
      else if (dbCnt != DB_LAST) dbCnt <= dbCnt + DB_W'(1);
      if (swEv) sData <= swSync2;
    end
  end

  // ---------------- timer ----------------
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      preCnt <= '0;
      tCnt   <= '0;
      tLim   <= '0;
    end else begin
      if (tcntWr || tick) preCnt <= '0;
      else                preCnt <= preCnt + PRE_W'(1);
      if (tcntWr)     tCnt <= bus.wdata;
      else if (tmrEv) tCnt <= '0;
      else if (tick)  tCnt <= tCnt + DBITS'(1);
      if (wr && sel == SEL_TLIM) tLim <= bus.wdata;
    end
  end

  // ---------------- outputs ----------------
  always_comb begin
    HEX = '1;
    for (int unsigned i = 0; i < NUM_HEX; i++) begin
      HEX[7*i +: 7] = seg7(hexData[4*i +: 4]);
    end
  end

  assign LEDR = ledrData;
  assign irq  = |(ready & ie);

endmodule

// File: tb/tb_mmio_io_hub.sv
// Directed bench for mmio_io_hub with a cycle-level behavioural model and per-cycle compare.
module tb_mmio_io_hub;

  localparam int DEB  = 4;
  localparam int TICK = 3;
  localparam logic [31:0] A_HEX   = 32'hF0000000;
  localparam logic [31:0] A_LEDR  = 32'hF0000004;
  localparam logic [31:0] A_KDATA = 32'hF0000010;
  localparam logic [31:0] A_SDATA = 32'hF0000014;
  localparam logic [31:0] A_TCNT  = 32'hF0000020;
  localparam logic [31:0] A_TLIM  = 32'hF0000024;
  localparam logic [31:0] A_KCTRL = 32'hF0000110;
  localparam logic [31:0] A_SCTRL = 32'hF0000114;
  localparam logic [31:0] A_TCTRL = 32'hF0000120;

  logic        clk    = 1'b0;
  logic        resetN = 1'b0;
  logic [3:0]  KEY    = 4'hF;
  logic [9:0]  SW     = '0;
  logic [9:0]  LEDR;
  logic [27:0] HEX;
  logic        irq;

  int nVec  = 0;
  int nErr  = 0;
  bit cmpEn = 1'b0;

  mmio_io_hub_if #(.DBITS(32)) bus();

  mmio_io_hub #(
    .DEBOUNCE_CYCLES  (DEB),
    .TIMER_TICK_CYCLES(TICK)
  ) dut (
    .clk  (clk),
    .reset(resetN),
    .bus  (bus),
    .KEY  (KEY),
    .SW   (SW),
    .LEDR (LEDR),
    .HEX  (HEX),
    .irq  (irq)
  );

  always #5 clk = ~clk;

  logic [6:0] segTab [16] = '{
    7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
    7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
    7'b0000000, 7'b0010000, 7'b0001000, 7'b0000011,
    7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110
  };

  // ---------------- behavioural model ----------------
  logic [15:0] mHex;
  logic [9:0]  mLed;
  logic [3:0]  mKeyS1, mKdata;
  logic [9:0]  mSwS1, mSwS2, mSdata;
  int          mHold, mPhase;
  logic [31:0] mTcnt, mTlim;
  logic [2:0]  mRdy, mOv, mIe;

  function automatic bit mHitFn(input logic [31:0] a);
    case (a)
      A_HEX, A_LEDR, A_KDATA, A_SDATA, A_TCNT, A_TLIM, A_KCTRL, A_SCTRL, A_TCTRL: return 1'b1;
      default: return 1'b0;
    endcase
  endfunction

  function automatic logic [31:0] mCtrl(input int i);
    return {27'd0, mIe[i], 1'b0, mOv[i], 1'b0, mRdy[i]};
  endfunction

  function automatic logic [31:0] mRead(input logic [31:0] a);
    case (a)
      A_HEX:   return {16'd0, mHex};
      A_LEDR:  return {22'd0, mLed};
      A_KDATA: return {28'd0, mKdata};
      A_SDATA: return {22'd0, mSdata};
      A_TCNT:  return mTcnt;
      A_TLIM:  return mTlim;
      A_KCTRL: return mCtrl(0);
      A_SCTRL: return mCtrl(1);
      A_TCTRL: return mCtrl(2);
      default: return 32'd0;
    endcase
  endfunction

  function automatic logic [27:0] mHexOut();
    logic [27:0] h;
    for (int d = 0; d < 4; d++) h[7*d +: 7] = segTab[mHex[4*d +: 4]];
    return h;
  endfunction

  task automatic modelStep();
    bit isWr, tk, tw, clrR, clrO;
    bit [2:0] ev, rdc, cw;
    isWr = bus.we && mHitFn(bus.addr);
    tk   = (mPhase == TICK - 1);
    tw   = isWr && (bus.addr == A_TCNT);
    // key value changes two edges after the pin; switches need DEB held cycles
    ev[0] = (mKeyS1 != mKdata);
    ev[1] = (mHold >= DEB) && (mSwS2 != mSdata);
    ev[2] = tk && !tw && (mTlim != 0) && (mTcnt == mTlim - 1);
    rdc   = {1'b0, bus.re && bus.addr == A_SDATA, bus.re && bus.addr == A_KDATA};
    cw    = {isWr && bus.addr == A_TCTRL, isWr && bus.addr == A_SCTRL, isWr && bus.addr == A_KCTRL};
    for (int i = 0; i < 3; i++) begin
      clrR   = rdc[i] || (cw[i] && !bus.wdata[0]);
      clrO   = cw[i] && !bus.wdata[2];
      mOv[i] = (ev[i] && mRdy[i] && !clrR) || (mOv[i] && !clrO);
      mRdy[i] = ev[i] || (mRdy[i] && !clrR);
      if (cw[i]) mIe[i] = bus.wdata[4];
    end
    if (ev[1]) mSdata = mSwS2;
    if (mSwS1 != mSwS2) mHold = 1;
    else if (mHold < DEB) mHold = mHold + 1;
    mSwS2  = mSwS1;
    mSwS1  = SW;
    mKdata = mKeyS1;
    mKeyS1 = ~KEY;
    if (tw) mTcnt = bus.wdata;
    else if (tk) mTcnt = ev[2] ? 32'd0 : mTcnt + 32'd1;
    mPhase = (tw || tk) ? 0 : mPhase + 1;
    if (isWr && bus.addr == A_TLIM) mTlim = bus.wdata;
    if (isWr && bus.addr == A_HEX)  mHex  = bus.wdata[15:0];
    if (isWr && bus.addr == A_LEDR) mLed  = bus.wdata[9:0];
  endtask

  task automatic modelReset();
    mHex = '0; mLed = '0; mKeyS1 = '0; mKdata = '0;
    mSwS1 = '0; mSwS2 = '0; mSdata = '0; mHold = 1; mPhase = 0;
    mTcnt = '0; mTlim = '0; mRdy = '0; mOv = '0; mIe = '0;
  endtask

  initial forever begin
    @(posedge clk or negedge resetN);
    if (!resetN) modelReset();
    else         modelStep();
  end

  // ---------------- checking ----------------
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    nVec++;
    if (act !== exp) begin
      nErr++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  initial forever begin
    @(negedge clk);
    if (cmpEn) begin
      check("cyc_hit",   {31'd0, bus.hit}, {31'd0, mHitFn(bus.addr)});
      check("cyc_rdata", bus.rdata, mRead(bus.addr));
      check("cyc_LEDR",  {22'd0, LEDR}, {22'd0, mLed});
      check("cyc_HEX",   {4'd0, HEX}, {4'd0, mHexOut()});
      check("cyc_irq",   {31'd0, irq}, {31'd0, |(mRdy & mIe)});
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected $finish");
    $fatal(1);
  end

  // ---------------- stimulus helpers ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic busWrite(input logic [31:0] a, input logic [31:0] d);
    bus.addr = a; bus.wdata = d; bus.we = 1'b1; bus.re = 1'b0;
    tick();
    bus.we = 1'b0;
  endtask

  task automatic peek(input string name, input logic [31:0] a, input logic [31:0] exp);
    bus.addr = a; bus.re = 1'b0;
    #1;
    check(name, bus.rdata, exp);
  endtask

  task automatic readClr(input string name, input logic [31:0] a, input logic [31:0] exp);
    bus.addr = a; bus.re = 1'b1;
    #1;
    check(name, bus.rdata, exp);
    tick();
    bus.re = 1'b0;
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    int n;
    bus.addr = '0; bus.wdata = '0; bus.we = 1'b0; bus.re = 1'b0;
    tick();
    cmpEn = 1'b1;
    repeat (2) tick();

    // reset values
    check("rst_LEDR", {22'd0, LEDR}, 32'd0);
    check("rst_HEX",  {4'd0, HEX}, {4'd0, {4{7'b1000000}}});
    check("rst_irq",  {31'd0, irq}, 32'd0);
    peek("rst_KCTRL", A_KCTRL, 32'd0);
    resetN = 1'b1;
    tick();

    // 1: HEX / LEDR
    busWrite(A_HEX, 32'h0000ABCD);
    busWrite(A_LEDR, 32'hFFFFFFFF);
    check("hex_digit0", {25'd0, HEX[6:0]}, {25'd0, 7'b0100001});
    check("hex_all",    {4'd0, HEX}, {4'd0, 7'b0001000, 7'b0000011, 7'b1000110, 7'b0100001});
    check("ledr_all",   {22'd0, LEDR}, 32'h3FF);
    peek("hex_read", A_HEX, 32'h0000ABCD);

    // 2: keys
    KEY = 4'b1110;
    tick();
    peek("key_1cyc", A_KDATA, 32'd0);
    tick();
    peek("key_2cyc", A_KDATA, 32'd1);
    peek("kctrl_rdy", A_KCTRL, 32'd1);
    KEY = 4'hF; repeat (2) tick();
    KEY = 4'hE; repeat (2) tick();
    peek("kctrl_ovr", A_KCTRL, 32'd5);
    readClr("kdata_rd", A_KDATA, 32'd1);
    peek("kctrl_rdclr", A_KCTRL, 32'd4);
    busWrite(A_KCTRL, 32'd0);
    peek("kctrl_wrclr", A_KCTRL, 32'd0);

    // 3: switch debounce
    bus.addr = A_SDATA;
    for (int i = 0; i < 10; i++) begin
      SW = (i % 2 == 0) ? 10'h001 : 10'h000;
      repeat (2) tick();
    end
    peek("sw_bounce", A_SDATA, 32'd0);
    SW = 10'h155;
    repeat (5) tick();
    peek("sw_5cyc", A_SDATA, 32'd0);
    tick();
    peek("sw_6cyc", A_SDATA, 32'h155);
    peek("sctrl_rdy", A_SCTRL, 32'd1);

    // 4: timer
    busWrite(A_TLIM, 32'd3);
    busWrite(A_TCNT, 32'd0);
    busWrite(A_TCTRL, 32'd16);
    peek("tcnt_0", A_TCNT, 32'd0);
    repeat (2) tick();
    peek("tcnt_1", A_TCNT, 32'd1);
    repeat (3) tick();
    peek("tcnt_2", A_TCNT, 32'd2);
    repeat (3) tick();
    peek("tcnt_wrap", A_TCNT, 32'd0);
    peek("tctrl_rdy", A_TCTRL, 32'd17);
    check("irq_tmr", {31'd0, irq}, 32'd1);
    repeat (9) tick();
    peek("tctrl_ovr", A_TCTRL, 32'd21);

    // 5a: key event with same-cycle Ready-clearing write
    KEY = 4'hC; repeat (2) tick();
    peek("kctrl_pre", A_KCTRL, 32'd1);
    KEY = 4'h8; tick();
    busWrite(A_KCTRL, 32'd0);
    peek("kctrl_race", A_KCTRL, 32'd1);
    peek("kdata_race", A_KDATA, 32'd7);

    // 5b: TCNT write coinciding with a prescaler tick
    n = 0;
    while (mPhase != TICK - 1 && n < 10) begin
      tick();
      n++;
    end
    check("tick_align", {31'd0, n < 10}, 32'd1);
    busWrite(A_TCNT, 32'd7);
    peek("tcnt_race", A_TCNT, 32'd7);

    // 6: asynchronous reset mid-operation
    SW = 10'h0AA;
    repeat (2) tick();
    busWrite(A_TCNT, 32'd2);
    peek("tcnt_prerst", A_TCNT, 32'd2);
    check("irq_prerst", {31'd0, irq}, 32'd1);
    resetN = 1'b0;
    #1;
    check("arst_irq",  {31'd0, irq}, 32'd0);
    check("arst_LEDR", {22'd0, LEDR}, 32'd0);
    check("arst_HEX",  {4'd0, HEX}, {4'd0, {4{7'b1000000}}});
    tick();
    peek("arst_TCNT",  A_TCNT, 32'd0);
    peek("arst_TLIM",  A_TLIM, 32'd0);
    peek("arst_SDATA", A_SDATA, 32'd0);
    tick();
    peek("arst_TCTRL", A_TCTRL, 32'd0);
    peek("arst_KDATA", A_KDATA, 32'd0);
    resetN = 1'b1;
    bus.addr = 32'hF0000030;
    #1;
    check("unmapped_hit",   {31'd0, bus.hit}, 32'd0);
    check("unmapped_rdata", bus.rdata, 32'd0);
    bus.addr = A_SDATA;
    repeat (5) tick();
    peek("sw_post_5", A_SDATA, 32'd0);
    tick();
    peek("sw_post_6", A_SDATA, 32'h0AA);
    repeat (3) tick();

    cmpEn = 1'b0;
    $display("== %0d vectors applied, %0d miscompares ==", nVec, nErr);
    $finish;
  end

endmodule
